mil_rx_frame_assembler: RTL and testbench

//  Sits directly downstream of milReceiver. Consumes its push stream of decoded words (type + 16-bit word)
//  and groups each command word with its data words into a frame. Emits the frame to the SPI-side buffer

---
 rtl/mil_rx_frame_assembler.sv | 238 +++++++++++++++++++++++
 tb/tb_mil_rx_frame_assembler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mil_rx_frame_assembler.sv
// Groups milReceiver words into frames (command, data words, status trailer) and queues them in a FIFO.
// Optional build macro MIL_FRAME_STATS_EN enables saturating frame/error counters; otherwise both read 0.
module mil_rx_frame_assembler #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_request,
  input  logic [1:0]  in_type,
  input  logic [15:0] in_word,
  output logic        in_done,
  output logic        out_request,
  output logic [15:0] out_data,
  input  logic        out_done,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_errors
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] WDATA    = 2'd0;
  localparam logic [1:0] WCOMMAND = 2'd1;
  localparam logic [1:0] WSTATUS  = 2'd2;
  localparam logic [1:0] WERROR   = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_TRAIL = 2'd2;

  function automatic logic [15:0] f_trailer(input logic tmo, input logic shrt, input logic err,
                                            input logic sts, input logic [4:0] rt, input logic [5:0] cnt);
    return {tmo, shrt, err, sts, 1'b0, rt, cnt};
  endfunction

  logic [1:0]    r_state;
  logic [4:0]    r_rt;
  logic [5:0]    r_exp, r_rcvd;
  logic [GW-1:0] r_gap;
  logic          r_in_done;
  logic [1:0]    r_wr_n;
  logic [15:0]   r_wr_d0, r_wr_d1;
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [15:0]   r_out_data;

  logic [1:0]    w_state_nxt;
  logic [4:0]    w_rt_nxt;
  logic [5:0]    w_exp_nxt, w_rcvd_nxt, w_cmd_exp, w_rcvd_inc;
  logic          w_accept, w_trailer_wr, w_trailer_err, w_orphan;
  logic [1:0]    w_wr_n;
  logic [15:0]   w_wr_d0, w_wr_d1;
  logic [CW-1:0] w_room, w_count_np;
  logic [AW-1:0] w_rd_np;
  logic          w_has1, w_has2, w_req, w_timeout, w_pop;

  // Room excludes the words still staged for the memory, so a pop never frees a slot the same cycle.
  assign w_room     = CW'(FIFO_DEPTH) - r_count - CW'(r_wr_n);
  assign w_has1     = w_room >= CW'(1);
  assign w_has2     = w_room >= CW'(2);
  assign w_req      = in_request && !r_in_done;
  assign w_timeout  = r_gap >= GW'(TIMEOUT_CYCLES - 1);
  assign w_cmd_exp  = in_word[10] ? 6'd0 : ((in_word[4:0] == 5'd0) ? 6'd32 : {1'b0, in_word[4:0]});
  assign w_rcvd_inc = r_rcvd + 6'd1;
  assign w_pop      = r_out_valid && out_done;
  assign w_count_np = r_count - CW'(w_pop);
  assign w_rd_np    = r_rd_ptr + AW'(w_pop);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt   = r_state;
    w_rt_nxt      = r_rt;
    w_exp_nxt     = r_exp;
    w_rcvd_nxt    = r_rcvd;
    w_accept      = 1'b0;
    w_trailer_wr  = 1'b0;
    w_trailer_err = 1'b0;
    w_orphan      = 1'b0;
    w_wr_n        = 2'd0;
    w_wr_d0       = 16'h0;
    w_wr_d1       = 16'h0;
    case (r_state)
      S_IDLE: if (w_req) begin
        case (in_type)
          WCOMMAND: if (w_has1) begin
            w_accept    = 1'b1;
            w_wr_n      = 2'd1;
            w_wr_d0     = in_word;
            w_rt_nxt    = in_word[15:11];
            w_exp_nxt   = w_cmd_exp;
            w_rcvd_nxt  = 6'd0;
            w_state_nxt = (w_cmd_exp == 6'd0) ? S_TRAIL : S_DATA;
          end
          WDATA: begin
            w_accept = 1'b1;
            w_orphan = 1'b1;
          end
          WERROR: w_accept = 1'b1;
          WSTATUS: if (w_has2) begin
            w_accept     = 1'b1;
            w_wr_n       = 2'd2;
            w_wr_d0      = in_word;
            w_wr_d1      = f_trailer(1'b0, 1'b0, 1'b0, 1'b1, in_word[15:11], 6'd0);
            w_trailer_wr = 1'b1;
          end
        endcase
      end
      S_DATA: if (w_timeout) begin
        if (w_has1) begin
          w_wr_n        = 2'd1;
          w_wr_d0       = f_trailer(1'b1, 1'b0, 1'b0, 1'b0, r_rt, r_rcvd);
          w_trailer_wr  = 1'b1;
          w_trailer_err = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end else if (w_req) begin
        case (in_type)
          WDATA: if (w_has1) begin
            w_accept    = 1'b1;
            w_wr_n      = 2'd1;
            w_wr_d0     = in_word;
            w_rcvd_nxt  = w_rcvd_inc;
            if (w_rcvd_inc == r_exp) w_state_nxt = S_TRAIL;
          end
          WCOMMAND: if (w_has2) begin
            w_accept      = 1'b1;
            w_wr_n        = 2'd2;
            w_wr_d0       = f_trailer(1'b0, 1'b1, 1'b0, 1'b0, r_rt, r_rcvd);
            w_wr_d1       = in_word;
            w_trailer_wr  = 1'b1;
            w_trailer_err = 1'b1;
            w_rt_nxt      = in_word[15:11];
            w_exp_nxt     = w_cmd_exp;
            w_rcvd_nxt    = 6'd0;
            w_state_nxt   = (w_cmd_exp == 6'd0) ? S_TRAIL : S_DATA;
          end
          WERROR: if (w_has1) begin
            w_accept      = 1'b1;
            w_wr_n        = 2'd1;
            w_wr_d0       = f_trailer(1'b0, 1'b0, 1'b1, 1'b0, r_rt, r_rcvd);
            w_trailer_wr  = 1'b1;
            w_trailer_err = 1'b1;
            w_state_nxt   = S_IDLE;
          end
          // Status word is left pending: close the short frame now, S_IDLE accepts it next.
          WSTATUS: if (w_has1) begin
            w_wr_n        = 2'd1;
            w_wr_d0       = f_trailer(1'b0, 1'b1, 1'b0, 1'b0, r_rt, r_rcvd);
            w_trailer_wr  = 1'b1;
            w_trailer_err = 1'b1;
            w_state_nxt   = S_IDLE;
          end
        endcase
      end
      S_TRAIL: if (w_has1) begin
        w_wr_n       = 2'd1;
        w_wr_d0      = f_trailer(1'b0, 1'b0, 1'b0, 1'b0, r_rt, r_rcvd);
        w_trailer_wr = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rt        <= '0;
      r_exp       <= '0;
      r_rcvd      <= '0;
      r_gap       <= '0;
      r_in_done   <= 1'b0;
      r_wr_n      <= '0;
      r_wr_d0     <= '0;
      r_wr_d1     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rt        <= w_rt_nxt;
      r_exp       <= w_exp_nxt;
      r_rcvd      <= w_rcvd_nxt;
      r_in_done   <= w_accept;
      r_wr_n      <= w_wr_n;
      r_wr_d0     <= w_wr_d0;
      r_wr_d1     <= w_wr_d1;
      if (r_state != S_DATA || w_accept) r_gap <= '0;
      else if (!w_timeout)               r_gap <= r_gap + GW'(1);
      r_wr_ptr    <= r_wr_ptr + AW'(r_wr_n);
      r_rd_ptr    <= w_rd_np;
      r_count     <= w_count_np + CW'(r_wr_n);
      // Head is reloaded only from words already in memory, which keeps two cycles after in_done.
      r_out_valid <= w_count_np != '0;
      r_out_data  <= (w_count_np != '0) ? r_mem[w_rd_np] : 16'h0;
    end
  end

  // NOTE: storage is not reset; r_count and r_out_valid alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (r_wr_n != 2'd0) r_mem[r_wr_ptr]           <= r_wr_d0;
    if (r_wr_n == 2'd2) r_mem[r_wr_ptr + AW'(1)]  <= r_wr_d1;
  end

  assign in_done     = r_in_done;
  assign out_request = r_out_valid;
  assign out_data    = r_out_data;

`ifdef MIL_FRAME_STATS_EN
  logic [15:0] r_stat_frames, r_stat_errors;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_frames <= '0;
      r_stat_errors <= '0;
    end else begin
      if (w_trailer_wr && r_stat_frames != 16'hFFFF) r_stat_frames <= r_stat_frames + 16'd1;
      if ((w_trailer_err || w_orphan) && r_stat_errors != 16'hFFFF) r_stat_errors <= r_stat_errors + 16'd1;
    end
  end

  assign stat_frames = r_stat_frames;
  assign stat_errors = r_stat_errors;
`else
  logic w_stats_unused;
  assign w_stats_unused = w_trailer_wr ^ w_trailer_err ^ w_orphan;
  assign stat_frames    = 16'h0;
  assign stat_errors    = 16'h0;
`endif

endmodule

// File: tb/tb_mil_rx_frame_assembler.sv
// Directed bench for mil_rx_frame_assembler: frames, orphans, short/timeout/error/status trailers, backpressure, reset.
module tb_mil_rx_frame_assembler;

  localparam int TMO = 1500;
  localparam logic [1:0] WDATA = 2'd0, WCOMMAND = 2'd1, WSTATUS = 2'd2, WERROR = 2'd3;
`ifdef MIL_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_request;
  logic [1:0]  in_type;
  logic [15:0] in_word;
  logic        in_done;
  logic        out_request;
  logic [15:0] out_data;
  logic        out_done;
  logic [15:0] stat_frames, stat_errors;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit consume_en = 1'b0;
  logic [15:0] rx_q[$];
  logic [15:0] exp_q[$];

  mil_rx_frame_assembler #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .in_request(in_request), .in_type(in_type), .in_word(in_word),
    .in_done(in_done), .out_request(out_request), .out_data(out_data), .out_done(out_done),
    .stat_frames(stat_frames), .stat_errors(stat_errors)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_done = 1'b0;
    forever begin
      @(negedge clk);
      if (consume_en && out_request === 1'b1 && !rst) begin
        rx_q.push_back(out_data);
        out_done = 1'b1;
      end else begin
        out_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_request = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
  endtask

  task automatic send(input logic [1:0] t, input logic [15:0] w);
    bit ok = 1'b0;
    @(negedge clk);
    in_type = t;
    in_word = w;
    in_request = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (in_done === 1'b1) begin ok = 1'b1; break; end
    end
    in_request = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept type=%0d word=%h: in_done stayed 0, required 1 within 300 cycles", t, w);
    end else begin
      @(posedge clk); #1;
      checks++;
      if (in_done !== 1'b0) begin
        errors++;
        $display("FAIL in_done_width word=%h: in_done=%b on 2nd cycle, required 0", w, in_done);
      end
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int i = 0;
    while (rx_q.size() < n && i < budget) begin @(posedge clk); i++; end
    repeat (12) @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_request = 1'b0; in_type = WDATA; in_word = 16'h0;
    #1;
    checks++;
    if ({in_done, out_request, out_data, stat_frames, stat_errors} !== 50'd0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b req=%b data=%h frames=%h errors=%h, required all 0",
               in_done, out_request, out_data, stat_frames, stat_errors);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_orphan();
    do_reset(); consume_en = 1'b1;
    send(WCOMMAND, 16'hEFAB);
    send(WDATA, 16'h02A1);
    exp_q = '{16'hEFAB, 16'h0740};
    wait_rx(exp_q.size(), 200);
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL orphan_count: got %0d words, required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL orphan_word[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (stat_frames !== (STATS ? 16'd1 : 16'd0) || stat_errors !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL orphan_stats: got frames=%0d errors=%0d, required %0d/%0d", stat_frames, stat_errors, STATS, STATS);
    end
  endtask

  task automatic test_data_frame(input bit with_reset);
    if (with_reset) do_reset();
    consume_en = 1'b1;
    send(WCOMMAND, 16'h1822);
    send(WDATA, 16'h1111);
    send(WDATA, 16'h2222);
    exp_q = '{16'h1822, 16'h1111, 16'h2222, 16'h00C2};
    wait_rx(exp_q.size(), 200);
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL frame_count: got %0d words, required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame_word[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (stat_frames !== (STATS ? 16'd1 : 16'd0) || stat_errors !== 16'd0) begin
      errors++; $display("FAIL frame_stats: got frames=%0d errors=%0d, required %0d/0", stat_frames, stat_errors, STATS);
    end
  endtask

  task automatic test_wc32();
    do_reset(); consume_en = 1'b1;
    exp_q = '{16'h1820};
    send(WCOMMAND, 16'h1820);
    for (int i = 0; i < 32; i++) begin
      send(WDATA, 16'(i));
      exp_q.push_back(16'(i));
    end
    exp_q.push_back(16'h00E0);
    wait_rx(exp_q.size(), 300);
    checks++;
    if (rx_q.size() != 34) begin errors++; $display("FAIL wc32_count: got %0d words, required 34", rx_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL wc32_word[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int t0, elapsed;
    do_reset(); consume_en = 1'b1;
    send(WCOMMAND, 16'h1822);
    send(WDATA, 16'h1111);
    t0 = cyc;
    exp_q = '{16'h1822, 16'h1111, 16'h80C1};
    while (rx_q.size() < 3 && cyc - t0 < 2500) @(posedge clk);
    elapsed = cyc - t0;
    checks++;
    if (rx_q.size() != 3) begin errors++; $display("FAIL timeout_count: got %0d words, required 3", rx_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_word[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (elapsed < TMO || elapsed > TMO + 20) begin
      errors++; $display("FAIL timeout_delay: trailer after %0d cycles, required %0d..%0d", elapsed, TMO, TMO + 20);
    end
    checks++;
    if (stat_frames !== (STATS ? 16'd1 : 16'd0) || stat_errors !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL timeout_stats: got frames=%0d errors=%0d, required %0d/%0d", stat_frames, stat_errors, STATS, STATS);
    end
  endtask

  task automatic test_short_frame();
    do_reset(); consume_en = 1'b1;
    send(WCOMMAND, 16'h1822);
    send(WDATA, 16'h1111);
    send(WCOMMAND, 16'h1821);
    send(WDATA, 16'h3333);
    exp_q = '{16'h1822, 16'h1111, 16'h40C1, 16'h1821, 16'h3333, 16'h00C1};
    wait_rx(exp_q.size(), 200);
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL short_count: got %0d words, required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_word[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (stat_frames !== (STATS ? 16'd2 : 16'd0) || stat_errors !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL short_stats: got frames=%0d errors=%0d", stat_frames, stat_errors);
    end
  endtask

  task automatic test_status_error();
    do_reset(); consume_en = 1'b1;
    send(WERROR, 16'hFFFF);
    send(WSTATUS, 16'h1800);
    send(WCOMMAND, 16'h1822);
    send(WDATA, 16'h1111);
    send(WERROR, 16'h0000);
    send(WCOMMAND, 16'h1822);
    send(WSTATUS, 16'h2000);
    exp_q = '{16'h1800, 16'h10C0, 16'h1822, 16'h1111, 16'h20C1, 16'h1822, 16'h40C0, 16'h2000, 16'h1100};
    wait_rx(exp_q.size(), 200);
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL status_count: got %0d words, required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL status_word[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (stat_frames !== (STATS ? 16'd4 : 16'd0) || stat_errors !== (STATS ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL status_stats: got frames=%0d errors=%0d", stat_frames, stat_errors);
    end
  endtask

  task automatic test_backpressure_reset();
    bit stalled = 1'b1;
    bit ok = 1'b0;
    do_reset(); consume_en = 1'b0;
    exp_q = '{16'h1820};
    send(WCOMMAND, 16'h1820);
    for (int i = 0; i < 15; i++) begin
      send(WDATA, 16'hA000 + 16'(i));
      exp_q.push_back(16'hA000 + 16'(i));
    end
    @(negedge clk);
    in_type = WDATA; in_word = 16'hA00F; in_request = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (in_done === 1'b1) stalled = 1'b0;
    end
    checks++;
    if (!stalled) begin errors++; $display("FAIL full_stall: in_done=1 with 16 words queued, required 0"); end
    checks++;
    if (out_request !== 1'b1 || out_data !== 16'h1820) begin
      errors++; $display("FAIL full_head: got req=%b data=%h, required 1/1820", out_request, out_data);
    end
    consume_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (in_done === 1'b1) begin ok = 1'b1; break; end
    end
    in_request = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL full_release: in_done=0 after draining, required 1"); end
    exp_q.push_back(16'hA00F);
    for (int i = 16; i < 19; i++) begin
      send(WDATA, 16'hA000 + 16'(i));
      exp_q.push_back(16'hA000 + 16'(i));
    end
    wait_rx(20, 200);
    checks++;
    if (rx_q.size() != 20) begin errors++; $display("FAIL bp_count: got %0d words, required 20", rx_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
    end
    consume_en = 1'b0;
    send(WDATA, 16'hA013);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_request !== 1'b1 || out_data !== 16'hA013) begin
      errors++; $display("FAIL pre_reset_head: got req=%b data=%h, required 1/A013", out_request, out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_done, out_request, out_data, stat_frames, stat_errors} !== 50'd0) begin
      errors++; $display("FAIL midframe_reset: got done=%b req=%b data=%h frames=%h errors=%h, required all 0",
                         in_done, out_request, out_data, stat_frames, stat_errors);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    test_data_frame(1'b0);
  endtask

  initial begin
    rst = 1'b0;
    in_request = 1'b0;
    in_type = WDATA;
    in_word = 16'h0;
    test_reset();
    test_orphan();
    test_data_frame(1'b1);
    test_wc32();
    test_timeout();
    test_short_frame();
    test_status_error();
    test_backpressure_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
